// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exponent bias, exception-flag bit positions,
// canonical quiet NaN and the operand classifier.
package fpu_pkg;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // Flag vector is {invalid, overflow, underflow, inexact}
  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_NV = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1, zeros}, left in the low 1+exp_w+man_w bits
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    fp_qnan = '0;
    for (int i = 0; i < exp_w; i++) fp_qnan[man_w+i] = 1'b1;
    fp_qnan[man_w-1] = 1'b1;
  endfunction

  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero, input logic frac_msb);
    if (exp_zero) return frac_zero ? ZERO : SUB;
    if (exp_ones) return frac_zero ? INF : (frac_msb ? QNAN : SNAN);
    return NORM;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalise, round-to-nearest-even and pack the raw mantissa product.
// FMUL_DENORM_EN: tiny results are denormalised before rounding; otherwise
// they are flushed to signed zero and the alignment shifter is absent.
module fmul_round
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  esum,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [EXP_W+MAN_W:0]     res,
  output logic [3:0]               flags
);

  localparam int PW  = 2 * MAN_W + 2;
  localparam int LZW = $clog2(PW + 1);
  localparam int XW  = EXP_W + LZW + 3;
  localparam int XS  = MAN_W + 3;
  localparam int VW  = PW + XS;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE  = XW'(1);

  logic [LZW-1:0]             lz;
  logic [PW-1:0]              pn;
  logic signed [XW-1:0]       exp_n;
  logic [VW-1:0]              v;
  logic                       tiny;
  logic [MAN_W-1:0]           frac;
  logic                       g, r, s, inc, inexact, ovf;
  logic [EXP_W-1:0]           exp_f;
  logic [EXP_W+MAN_W-1:0]     sum;

  // Leading-zero count: the highest set bit is written last
  always_comb begin
    lz = LZW'(PW - 1);
    for (int i = 0; i < PW; i++) if (prod[i]) lz = LZW'(PW - 1 - i);
  end

  assign pn    = prod << lz;
  // A product with its top bit set is in [2,4), hence the +1
  assign exp_n = $signed({{(XW-EXP_W-2){esum[EXP_W+1]}}, esum}) + ONE
                 - $signed({{(XW-LZW){1'b0}}, lz});
  assign tiny  = (exp_n < ONE);

`ifdef FMUL_DENORM_EN
  localparam int SHW = $clog2(XS + 1);
  localparam logic signed [XW-1:0] XS_S = XW'(XS);

  logic signed [XW-1:0] dist;
  logic [SHW-1:0]       sh;

  assign dist = ONE - exp_n;
  // A saturated shift parks the hidden bit just below R, so it all lands in sticky
  assign sh   = !tiny ? '0 : ((dist > XS_S) ? SHW'(XS) : dist[SHW-1:0]);
  assign v    = {pn, {XS{1'b0}}} >> sh;
`else
  assign v    = {pn, {XS{1'b0}}};
`endif

  assign frac    = v[VW-2 -: MAN_W];
  assign g       = v[VW-2-MAN_W];
  assign r       = v[VW-3-MAN_W];
  assign s       = |v[VW-4-MAN_W:0];
  assign inexact = g | r | s;
  assign inc     = g & (r | s | frac[0]);
  assign exp_f   = tiny ? '0 : exp_n[EXP_W-1:0];
  // Carry out of the fraction bumps the exponent, covering both mantissa
  // overflow and a subnormal rounding up to the minimum normal
  assign sum     = {exp_f, frac} + {{(EXP_W+MAN_W-1){1'b0}}, inc};
  assign ovf     = (exp_n >= EMAX) || (&sum[EXP_W+MAN_W-1:MAN_W]);

  // Final result selection and exception flags
  always_comb begin
    res   = {sign, sum};
    flags = '0;
    if (ovf) begin
      res           = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else if (tiny) begin
`ifdef FMUL_DENORM_EN
      flags[FLG_UF] = inexact;
      flags[FLG_NX] = inexact;
`else
      res           = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLG_UF] = 1'b1;
      flags[FLG_NX] = 1'b1;
`endif
    end else begin
      flags[FLG_NX] = inexact;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready handshake.
// S1 classifies and sums exponents, S2 multiplies mantissas, S3 rounds.
// FMUL_DENORM_EN enables subnormal inputs/outputs; default is flush-to-zero.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_res,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic [63:0]  QNAN_ALL  = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] CANON_NAN = QNAN_ALL[W-1:0];

  logic                  stall;
  logic [EXP_W-1:0]      a_exp, b_exp, ea_eff, eb_eff;
  logic [MAN_W-1:0]      a_frac, b_frac;
  fp_class_e             cls_a, cls_b;
  logic                  zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_any, sign_p;
  logic [MW-1:0]         ma, mb;
  logic signed [EW-1:0]  esum;
  logic                  spec;
  logic [W-1:0]          spec_res;
  logic [3:0]            spec_flg;

  logic                  s1_valid, s1_sign, s1_spec;
  logic [MW-1:0]         s1_ma, s1_mb;
  logic signed [EW-1:0]  s1_esum;
  logic [W-1:0]          s1_spec_res;
  logic [3:0]            s1_spec_flg;
  logic [TAG_W-1:0]      s1_tag;

  logic                  s2_valid, s2_sign, s2_spec;
  logic [PW-1:0]         s2_prod;
  logic signed [EW-1:0]  s2_esum;
  logic [W-1:0]          s2_spec_res;
  logic [3:0]            s2_spec_flg;
  logic [TAG_W-1:0]      s2_tag;

  logic [W-1:0]          rnd_res;
  logic [3:0]            rnd_flg;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign a_exp  = in_a[W-2:MAN_W];
  assign b_exp  = in_b[W-2:MAN_W];
  assign a_frac = in_a[MAN_W-1:0];
  assign b_frac = in_b[MAN_W-1:0];
  assign sign_p = in_a[W-1] ^ in_b[W-1];

  assign cls_a = fp_classify(a_exp == '0, &a_exp, a_frac == '0, a_frac[MAN_W-1]);
  assign cls_b = fp_classify(b_exp == '0, &b_exp, b_frac == '0, b_frac[MAN_W-1]);

`ifdef FMUL_DENORM_EN
  assign zero_a = (cls_a == ZERO);
  assign zero_b = (cls_b == ZERO);
`else
  assign zero_a = (cls_a == ZERO) || (cls_a == SUB);
  assign zero_b = (cls_b == ZERO) || (cls_b == SUB);
`endif

  assign inf_a    = (cls_a == INF);
  assign inf_b    = (cls_b == INF);
  assign nan_a    = (cls_a == QNAN) || (cls_a == SNAN);
  assign nan_b    = (cls_b == QNAN) || (cls_b == SNAN);
  assign snan_any = (cls_a == SNAN) || (cls_b == SNAN);

  // Subnormals carry exponent 1 with no hidden bit; S3 renormalises them
  assign ea_eff = (a_exp == '0) ? EXP_W'(1) : a_exp;
  assign eb_eff = (b_exp == '0) ? EXP_W'(1) : b_exp;
  assign ma     = {cls_a == NORM, a_frac};
  assign mb     = {cls_b == NORM, b_frac};
  assign esum   = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - $signed(EW'(BIAS));

  // Special-operand result, decided up front and carried alongside the datapath
  always_comb begin
    spec     = 1'b0;
    spec_res = '0;
    spec_flg = '0;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      spec             = 1'b1;
      spec_res         = CANON_NAN;
      spec_flg[FLG_NV] = snan_any || (inf_a && zero_b) || (zero_a && inf_b);
    end else if (inf_a || inf_b) begin
      spec     = 1'b1;
      spec_res = {sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      spec     = 1'b1;
      spec_res = {sign_p, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  fmul_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round (
    .sign  (s2_sign),
    .esum  (s2_esum),
    .prod  (s2_prod),
    .res   (rnd_res),
    .flags (rnd_flg)
  );

  // All stages advance together; a blocked output freezes the whole pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_spec     <= 1'b0;
      s1_ma       <= '0;
      s1_mb       <= '0;
      s1_esum     <= '0;
      s1_spec_res <= '0;
      s1_spec_flg <= '0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_prod     <= '0;
      s2_esum     <= '0;
      s2_spec_res <= '0;
      s2_spec_flg <= '0;
      s2_tag      <= '0;
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_tag     <= '0;
      out_flags   <= '0;
    end else if (!stall) begin
      s1_valid    <= in_valid && in_ready;
      s1_sign     <= sign_p;
      s1_spec     <= spec;
      s1_ma       <= ma;
      s1_mb       <= mb;
      s1_esum     <= esum;
      s1_spec_res <= spec_res;
      s1_spec_flg <= spec_flg;
      s1_tag      <= in_tag;

      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
      s2_esum     <= s1_esum;
      s2_spec_res <= s1_spec_res;
      s2_spec_flg <= s1_spec_flg;
      s2_tag      <= s1_tag;

      out_valid   <= s2_valid;
      out_res     <= s2_spec ? s2_spec_res : rnd_res;
      out_flags   <= s2_spec ? s2_spec_flg : rnd_flg;
      out_tag     <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe at default binary32 parameters.
// Expected subnormal results depend on FMUL_DENORM_EN.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;
  logic [3:0]  out_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fmul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  // Drive one op with out_ready high; lat counts edges from the accept edge
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       output logic [31:0] res, output logic [3:0] flg,
                       output logic [4:0] otag, output int lat);
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = out_res;
    flg  = out_flags;
    otag = out_tag;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_res !== 32'h0) begin failures++; $display("FAIL reset_out_res: got %h want 0", out_res); end
    checks++; if (out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL reset_out_flags: got %b want 0", out_flags); end
  endtask

  task automatic test_basic;
    logic [31:0] res; logic [3:0] flg; logic [4:0] tg; int lat;
    do_op(32'h40000000, 32'h40400000, 5'h11, res, flg, tg, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency: got %0d want 3", lat); end
    checks++; if (res !== 32'h40C00000) begin failures++; $display("FAIL basic_res: got %h want 40c00000", res); end
    checks++; if (flg !== 4'b0000) begin failures++; $display("FAIL basic_flags: got %b want 0000", flg); end
    checks++; if (tg !== 5'h11) begin failures++; $display("FAIL basic_tag: got %h want 11", tg); end
  endtask

  task automatic test_rounding;
    logic [31:0] va [4] = '{32'h3F800001, 32'h3FC00000, 32'h3F800001, 32'h3F800003};
    logic [31:0] vb [4] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000};
    logic [31:0] vr [4] = '{32'h3F800002, 32'h40100000, 32'h3FC00002, 32'h3FC00004};
    logic [3:0]  vf [4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
    logic [31:0] res; logic [3:0] flg; logic [4:0] tg; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 5'(i), res, flg, tg, lat);
      checks++; if (res !== vr[i]) begin failures++; $display("FAIL round_res[%0d]: got %h want %h", i, res, vr[i]); end
      checks++; if (flg !== vf[i]) begin failures++; $display("FAIL round_flags[%0d]: got %b want %b", i, flg, vf[i]); end
    end
  endtask

  task automatic test_specials;
    logic [31:0] va [6] = '{32'h7F000000, 32'h7F800000, 32'h80000000, 32'h7FC00001, 32'h7F800001, 32'h7F800000};
    logic [31:0] vb [6] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hC0000000};
    logic [31:0] vr [6] = '{32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};
    logic [3:0]  vf [6] = '{4'b0101, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [31:0] res; logic [3:0] flg; logic [4:0] tg; int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], 5'(i + 4), res, flg, tg, lat);
      checks++; if (res !== vr[i]) begin failures++; $display("FAIL special_res[%0d]: got %h want %h", i, res, vr[i]); end
      checks++; if (flg !== vf[i]) begin failures++; $display("FAIL special_flags[%0d]: got %b want %b", i, flg, vf[i]); end
    end
  endtask

  task automatic test_subnormal;
    logic [31:0] res; logic [3:0] flg; logic [4:0] tg; int lat;
    logic [31:0] e1, e2; logic [3:0] f1;
`ifdef FMUL_DENORM_EN
    e1 = 32'h00400000; f1 = 4'b0000; e2 = 32'h00800000;
`else
    e1 = 32'h00000000; f1 = 4'b0011; e2 = 32'h00000000;
`endif
    do_op(32'h00800000, 32'h3F000000, 5'h1A, res, flg, tg, lat);
    checks++; if (res !== e1) begin failures++; $display("FAIL tiny_res: got %h want %h", res, e1); end
    checks++; if (flg !== f1) begin failures++; $display("FAIL tiny_flags: got %b want %b", flg, f1); end
    do_op(32'h00400000, 32'h40000000, 5'h1B, res, flg, tg, lat);
    checks++; if (res !== e2) begin failures++; $display("FAIL subin_res: got %h want %h", res, e2); end
    checks++; if (flg !== 4'b0000) begin failures++; $display("FAIL subin_flags: got %b want 0000", flg); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vb [3] = '{32'h40000000, 32'h40400000, 32'h40800000};
    logic exp_v;
    out_ready = 1'b1;
    in_a      = 32'h3F800000;
    for (int e = 1; e <= 6; e++) begin
      if (e <= 3) begin
        in_valid = 1'b1;
        in_b     = vb[e-1];
        in_tag   = 5'(7 + e);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      exp_v = (e >= 3) && (e <= 5);
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid[%0d]: got %b want %b", e, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_tag !== 5'(e + 5)) begin failures++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", e, out_tag, e + 5); end
        checks++; if (out_res !== vb[e-3]) begin failures++; $display("FAIL b2b_res[%0d]: got %h want %h", e, out_res, vb[e-3]); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] vb [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
    int sent = 0, rcvd = 0, cyc = 0;
    bit saw_block = 0;
    bit acc, xfer;
    in_a = 32'h3F800000;
    while (rcvd < 6 && cyc < 60) begin
      in_valid  = (sent < 6);
      in_b      = vb[(sent < 6) ? sent : 0];
      in_tag    = 5'(sent);
      out_ready = !(cyc >= 3 && cyc <= 8);
      @(negedge clk);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (out_valid) begin
        checks++; if (out_tag !== 5'(rcvd)) begin failures++; $display("FAIL bp_tag cyc%0d: got %0d want %0d", cyc, out_tag, rcvd); end
        checks++; if (out_res !== vb[rcvd]) begin failures++; $display("FAIL bp_res cyc%0d: got %h want %h", cyc, out_res, vb[rcvd]); end
        checks++; if (out_flags !== 4'b0000) begin failures++; $display("FAIL bp_flags cyc%0d: got %b want 0000", cyc, out_flags); end
      end
      if (!in_ready) begin
        saw_block = 1;
        checks++; if (sent - rcvd != 3) begin failures++; $display("FAIL bp_inflight cyc%0d: got %0d want 3", cyc, sent - rcvd); end
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (xfer) rcvd++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcvd != 6) begin failures++; $display("FAIL bp_count: got %0d want 6", rcvd); end
    checks++; if (!saw_block) begin failures++; $display("FAIL bp_in_ready_low: got never want seen"); end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] res; logic [3:0] flg; logic [4:0] tg; int lat;
    bit seen = 0;
    out_ready = 1'b1;
    in_a      = 32'h40000000;
    in_b      = 32'h40400000;
    in_valid  = 1'b1;
    in_tag    = 5'h01;
    @(posedge clk); #1;
    in_tag    = 5'h02;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rst_flush: got out_valid 1 want 0"); end
    do_op(32'h40000000, 32'h40400000, 5'h07, res, flg, tg, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rst_latency: got %0d want 3", lat); end
    checks++; if (res !== 32'h40C00000) begin failures++; $display("FAIL rst_res: got %h want 40c00000", res); end
    checks++; if (tg !== 5'h07) begin failures++; $display("FAIL rst_tag: got %h want 07", tg); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_subnormal();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
